dl_mem_writer: RTL
==================

Name: dl_mem_writer

Overview:
- Downstream stage of the download block: consumes its byte-write stream (wr/addr/data/downloading) and commits it to the shared system memory port via a req/ack handshake.
- Buffers bursts in a small FIFO and arbitrates the memory port between download writes and CPU accesses.
- Stalls the CPU while a download is active or still draining.
- Reports byte count, overflow and completion to the rest of the system.

Parameters:
- FIFO_DEPTH, 4, entries in the download write FIFO; power of two, minimum 2.
- ADDR_W, 25, width of download and memory addresses.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- dl_wr  in  1  write strobe from the download stage; a byte is taken on each 0->1 transition only.
- dl_addr  in  ADDR_W  download byte address.
- dl_data  in  8  download byte.
- dl_downloading  in  1  download-active flag from the download stage.
- cpu_req  in  1  CPU access request, level; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  16  CPU address, zero-extended to ADDR_W.
- cpu_din  in  8  CPU write data.
- cpu_dout  out  8  CPU read data, valid in the cpu_ack cycle.
- cpu_ack  out  1  one-cycle completion pulse for the CPU.
- cpu_wait  out  1  CPU stall.
- mem_req  out  1  memory request, level, held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_din  out  8  memory write data.
- mem_dout  in  8  memory read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion pulse from memory.
- byte_count  out  ADDR_W  download bytes committed since the last download start.
- overflow  out  1  sticky flag: a download byte was dropped.
- dl_complete  out  1  one-cycle pulse when the download has ended and the FIFO has drained.

Behaviour:
- Reset (asynchronous): FSM=IDLE, FIFO empty, all outputs 0, edge registers cleared to 0.
- Edge detection: dl_wr_q and dl_dn_q are registered copies.
  - push = dl_wr & ~dl_wr_q & dl_downloading.
  - dl_start = dl_downloading & ~dl_dn_q.
  - An idle-high dl_wr after the download ends is therefore ignored.
- dl_start clears byte_count and overflow in the same cycle. If push occurs in that same cycle, the byte is still accepted.
- FIFO:
  - push while full: the byte is dropped, overflow<=1, pointers unchanged.
  - push and pop in the same cycle are both legal at any fill level. Push on full with a simultaneous pop is accepted.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- cpu_wait = dl_downloading | ~fifo_empty | (state==DL_WR). It is combinational so the CPU stalls in the same cycle a download begins.
- FSM states:
  - IDLE:
    - If FIFO is not empty: pop the head into mem_addr/mem_din, set mem_we=1, mem_req=1, go to DL_WR. Download has priority.
    - Else if cpu_req & ~cpu_wait: drive mem_addr={zeros,cpu_addr}, mem_we=cpu_we, mem_din=cpu_din, mem_req=1, go to CPU_ACC.
  - DL_WR: hold all mem_* stable. On mem_ack: mem_req<=0, byte_count<=byte_count+1 (wraps modulo 2^ADDR_W), go to IDLE.
  - CPU_ACC: hold all mem_* stable. On mem_ack: mem_req<=0, cpu_ack<=1 for one cycle, cpu_dout<=mem_dout on reads (unchanged on writes), go to IDLE.
- Timing and back-to-back behaviour:
  - The earliest new mem_req comes one cycle after mem_ack, so there is at least one idle cycle between requests.
  - Best-case latency from push to mem_req is 2 cycles: push registered, then popped in IDLE.
- A CPU access already in CPU_ACC when a download starts completes normally. The download bytes wait in the FIFO.
- dl_complete fires one cycle when the falling edge of dl_downloading has been seen (tracked by a pending flag) and the FIFO is empty with FSM in IDLE.
  - If a new dl_start arrives before completion, the pending flag is cleared and no pulse is issued.
- Reset mid-transaction: mem_req drops immediately. The memory side must tolerate an abandoned request.

Test Plan:
- Download 3 bytes: addr 0x0000..0x0002, data A5,5A,3C, mem_ack 1 cycle after each req. Expect mem writes in order, byte_count=3, one dl_complete pulse after the last ack, overflow=0.
- Stall memory (mem_ack withheld 20 cycles) while pushing 6 bytes with FIFO_DEPTH=4. Expect the first byte in DL_WR, 4 bytes buffered, 1 dropped, overflow=1, final byte_count=5.
- dl_wr held high across 10 cycles after one rising edge. Expect exactly one byte written. dl_wr held high after dl_downloading falls: no writes.
- CPU read of 0x1234 with mem_dout=0x77 while idle. Expect mem_we=0, mem_addr=0x0001234, cpu_ack pulse with cpu_dout=0x77. Repeat with dl_downloading=1: cpu_wait=1, no mem_req for the CPU until drain.
- cpu_req and the first push in the same cycle from IDLE. Expect the download write first, the CPU served only after dl_downloading=0 and the FIFO is empty.
- Assert reset while in DL_WR with 2 entries queued. Expect mem_req=0 immediately, FIFO empty, byte_count=0, overflow=0, and a subsequent download working normally.

Source files
------------

// File: rtl/dl_mem_writer.sv
// Download write committer: buffers download bytes and shares the system
// memory port with the CPU, stalling the CPU until the download drains.
module dl_mem_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_data,
  input  logic              dl_downloading,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              cpu_ack,
  output logic              cpu_wait,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] byte_count,
  output logic              overflow,
  output logic              dl_complete
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    DL_WR,
    CPU_ACC
  } state_t;

  state_t state_q, state_d;

  logic              dl_wr_q;
  logic              dl_dn_q;
  logic              pend_q;
  logic [PW-1:0]     wp_q;
  logic [PW-1:0]     rp_q;
  logic [ADDR_W-1:0] f_addr [FIFO_DEPTH];
  logic [7:0]        f_data [FIFO_DEPTH];

  logic push;
  logic dl_start;
  logic dl_end;
  logic empty;
  logic full;
  logic pop;
  logic acc;
  logic drop;
  logic start_dl;
  logic start_cpu;
  logic done;

  assign push     = dl_wr & ~dl_wr_q & dl_downloading;
  assign dl_start = dl_downloading & ~dl_dn_q;
  assign dl_end   = ~dl_downloading & dl_dn_q;

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW] != rp_q[AW]) &&
                 (wp_q[AW-1:0] == rp_q[AW-1:0]);

  // A pop frees a slot in the same cycle, so a push on full still fits
  assign pop  = start_dl;
  assign acc  = push & (~full | pop);
  assign drop = push & full & ~pop;

  assign cpu_wait = dl_downloading | ~empty | (state_q == DL_WR);

  assign done = pend_q & empty & (state_q == IDLE) & ~dl_start;

  always_comb begin
    state_d   = state_q;
    start_dl  = 1'b0;
    start_cpu = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          start_dl = 1'b1;
          state_d  = DL_WR;
        end else if (cpu_req && !cpu_wait) begin
          start_cpu = 1'b1;
          state_d   = CPU_ACC;
        end
      end
      DL_WR, CPU_ACC: begin
        if (mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      f_addr[wp_q[AW-1:0]] <= dl_addr;
      f_data[wp_q[AW-1:0]] <= dl_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      dl_wr_q     <= 1'b0;
      dl_dn_q     <= 1'b0;
      pend_q      <= 1'b0;
      wp_q        <= '0;
      rp_q        <= '0;
      cpu_dout    <= '0;
      cpu_ack     <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
      byte_count  <= '0;
      overflow    <= 1'b0;
      dl_complete <= 1'b0;
    end else begin
      state_q     <= state_d;
      dl_wr_q     <= dl_wr;
      dl_dn_q     <= dl_downloading;
      cpu_ack     <= 1'b0;
      dl_complete <= done;

      if (acc) wp_q <= wp_q + PW'(1);
      if (pop) rp_q <= rp_q + PW'(1);

      if (drop)          overflow <= 1'b1;
      else if (dl_start) overflow <= 1'b0;

      // A restart cancels a completion that has not yet been reported
      if (dl_start)    pend_q <= 1'b0;
      else if (dl_end) pend_q <= 1'b1;
      else if (done)   pend_q <= 1'b0;

      if (dl_start)
        byte_count <= '0;
      else if (state_q == DL_WR && mem_ack)
        byte_count <= byte_count + ADDR_W'(1);

      if (start_dl) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b1;
        mem_addr <= f_addr[rp_q[AW-1:0]];
        mem_din  <= f_data[rp_q[AW-1:0]];
      end else if (start_cpu) begin
        mem_req  <= 1'b1;
        mem_we   <= cpu_we;
        mem_addr <= ADDR_W'(cpu_addr);
        mem_din  <= cpu_din;
      end else if (state_q != IDLE && mem_ack) begin
        mem_req <= 1'b0;
        if (state_q == CPU_ACC) begin
          cpu_ack <= 1'b1;
          if (!mem_we) cpu_dout <= mem_dout;
        end
      end
    end
  end

endmodule
